// File: rtl/simpletest_pkg.sv
// Shared types, widths and golden result function for the simpletest datapath interface.
package simpletest_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_SUBMUL = 2'b00;
    localparam logic [SEL_W-1:0] SEL_IDLE   = 2'b11;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } rsp_entry_t;

    // Datapath result: (a-b)*(a+a) mod 2^DATA_W for SUBMUL, zero otherwise.
    function automatic logic [DATA_W-1:0] st_ref(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [SEL_W-1:0]  sel);
        logic [DATA_W-1:0] diff;
        logic [DATA_W-1:0] sum;
        diff = a - b;
        sum  = a + a;
        if (sel == SEL_SUBMUL) begin
            return diff * sum;
        end
        return '0;
    endfunction

endpackage

// File: rtl/st_rsp_fifo.sv
// First-word-fall-through response FIFO; depth need not be a power of two.
module st_rsp_fifo
    import simpletest_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  rsp_entry_t       push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output rsp_entry_t       head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop frees the slot a same-edge push needs when full.
    always_comb begin
        do_pop   = pop_i && (cnt_q != '0);
        do_push  = push_i && ((32'(cnt_q) < DEPTH) || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/simpletest_driver.sv
// Initiator for the simpletest datapath: issues registered operands, tracks results
// through a fixed-latency pipe and returns them via a credit-limited response FIFO.
module simpletest_driver
    import simpletest_pkg::*;
#(
    parameter int unsigned LAT       = 1,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [SEL_W-1:0]  req_sel,
    output logic              dp_rst,
    output logic [SEL_W-1:0]  dp_sel,
    output logic [DATA_W-1:0] dp_in1,
    output logic [DATA_W-1:0] dp_in2,
    input  logic [DATA_W-1:0] dp_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [SEL_W-1:0]  rsp_sel
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic                     rst_hold_q;
    logic                     dp_rst_q;
    logic [SEL_W-1:0]         dp_sel_q, dp_sel_d;
    logic [DATA_W-1:0]        dp_in1_q, dp_in1_d;
    logic [DATA_W-1:0]        dp_in2_q, dp_in2_d;
    logic [LAT:0]             pipe_v_q, pipe_v_d;
    logic [LAT:0][SEL_W-1:0]  pipe_sel_q, pipe_sel_d;
    logic [CNT_W-1:0]         inflight_q, inflight_d;
    logic [CNT_W-1:0]         fifo_cnt;
    logic                     accept;
    logic                     capture;
    rsp_entry_t               cap_entry;
    rsp_entry_t               head;

    // Credit covers both in-flight and stored results, so capture never overflows.
    assign req_ready = !dp_rst_q && ((32'(inflight_q) + 32'(fifo_cnt)) < RSP_DEPTH);
    assign accept    = req_valid && req_ready;
    assign capture   = pipe_v_q[LAT];

    always_comb begin
        dp_sel_d      = SEL_IDLE;
        dp_in1_d      = '0;
        dp_in2_d      = '0;
        pipe_v_d      = '0;
        pipe_sel_d    = '0;
        inflight_d    = inflight_q;
        if (accept) begin
            dp_sel_d = req_sel;
            dp_in1_d = req_a;
            dp_in2_d = req_b;
        end
        pipe_v_d[0]   = accept;
        pipe_sel_d[0] = req_sel;
        for (int unsigned k = 1; k <= LAT; k++) begin
            pipe_v_d[k]   = pipe_v_q[k-1];
            pipe_sel_d[k] = pipe_sel_q[k-1];
        end
        if (accept && !capture) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && capture) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // dp_rst is held one extra full cycle after rst_n is seen high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_hold_q <= 1'b1;
            dp_rst_q   <= 1'b1;
            dp_sel_q   <= SEL_IDLE;
            dp_in1_q   <= '0;
            dp_in2_q   <= '0;
            pipe_v_q   <= '0;
            pipe_sel_q <= '0;
            inflight_q <= '0;
        end else begin
            rst_hold_q <= 1'b0;
            dp_rst_q   <= rst_hold_q;
            dp_sel_q   <= dp_sel_d;
            dp_in1_q   <= dp_in1_d;
            dp_in2_q   <= dp_in2_d;
            pipe_v_q   <= pipe_v_d;
            pipe_sel_q <= pipe_sel_d;
            inflight_q <= inflight_d;
        end
    end

    assign cap_entry.sel  = pipe_sel_q[LAT];
    assign cap_entry.data = dp_out;

    st_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (capture),
        .push_data_i (cap_entry),
        .pop_i       (rsp_ready),
        .valid_o     (rsp_valid),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    assign dp_rst   = dp_rst_q;
    assign dp_sel   = dp_sel_q;
    assign dp_in1   = dp_in1_q;
    assign dp_in2   = dp_in2_q;
    assign rsp_data = head.data;
    assign rsp_sel  = head.sel;

endmodule

// File: tb/tb_simpletest_driver.sv
// Directed bench for simpletest_driver with a one-stage behavioural datapath.
module tb_simpletest_driver;
    import simpletest_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [SEL_W-1:0]  req_sel;
    logic              dp_rst;
    logic [SEL_W-1:0]  dp_sel;
    logic [DATA_W-1:0] dp_in1;
    logic [DATA_W-1:0] dp_in2;
    logic [DATA_W-1:0] dp_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [SEL_W-1:0]  rsp_sel;

    int n_tests = 0;
    int n_fail  = 0;
    rsp_entry_t exp_q[$];

    always #5 clk = ~clk;

    simpletest_driver #(.LAT(1), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .dp_rst    (dp_rst),
        .dp_sel    (dp_sel),
        .dp_in1    (dp_in1),
        .dp_in2    (dp_in2),
        .dp_out    (dp_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_sel   (rsp_sel)
    );

    // Datapath stand-in: one register stage, synchronous active-high reset.
    always @(posedge clk) dp_out <= dp_rst ? 8'h00 : st_ref(dp_in1, dp_in2, dp_sel);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_sel = '0;
        repeat (3) step();
        n_tests++;
        if (dp_rst !== 1'b1 || dp_sel !== 2'b11 || dp_in1 !== 8'h00 || dp_in2 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: dp_rst=%b dp_sel=%b in1=%h in2=%h want 1/11/00/00", dp_rst, dp_sel, dp_in1, dp_in2);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: rsp_valid=%b req_ready=%b want 0/0", rsp_valid, req_ready);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (dp_rst !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stretch: dp_rst=%b req_ready=%b want 1/0", dp_rst, req_ready);
        end
        step();
        n_tests++;
        if (dp_rst !== 1'b0 || req_ready !== 1'b1 || dp_sel !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release: dp_rst=%b req_ready=%b dp_sel=%b want 0/1/11", dp_rst, req_ready, dp_sel);
        end
    endtask

    task automatic test_single_op();
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic [1:0] ts [4];
        logic [7:0] te [4];
        ta = '{8'd5, 8'd3, 8'd200, 8'd5};
        tb = '{8'd3, 8'd5, 8'd100, 8'd3};
        ts = '{2'd0, 2'd0, 2'd0, 2'd1};
        te = '{8'h14, 8'hF4, 8'h40, 8'h00};
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_a = ta[i]; req_b = tb[i]; req_sel = ts[i]; rsp_ready = 1'b0;
            n_tests++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL single_ready[%0d]: req_ready=%b want 1", i, req_ready);
            end
            step();
            req_valid = 1'b0;
            n_tests++;
            if (dp_in1 !== ta[i] || dp_in2 !== tb[i] || dp_sel !== ts[i] || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_issue[%0d]: in1=%h in2=%h sel=%b rsp_valid=%b want %h/%h/%b/0",
                         i, dp_in1, dp_in2, dp_sel, rsp_valid, ta[i], tb[i], ts[i]);
            end
            step();
            n_tests++;
            if (rsp_valid !== 1'b0 || dp_sel !== 2'b11 || dp_in1 !== 8'h00) begin
                n_fail++;
                $display("FAIL single_idle[%0d]: rsp_valid=%b dp_sel=%b in1=%h want 0/11/00", i, rsp_valid, dp_sel, dp_in1);
            end
            step();
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== te[i] || rsp_sel !== ts[i]) begin
                n_fail++;
                $display("FAIL single_result[%0d]: valid=%b data=%h sel=%b want 1/%h/%b", i, rsp_valid, rsp_data, rsp_sel, te[i], ts[i]);
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            n_tests++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_pop[%0d]: rsp_valid=%b want 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got = 0;
        bit ready_drop = 1'b0;
        rsp_entry_t e;
        for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
            rsp_ready = 1'b1;
            if (sent < 16) begin
                req_valid = 1'b1;
                req_a = 8'($urandom);
                req_b = 8'($urandom);
                req_sel = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end else begin
                req_valid = 1'b0;
            end
            if (req_valid && !req_ready) ready_drop = 1'b1;
            if (req_valid && req_ready) begin
                e.sel = req_sel; e.data = st_ref(req_a, req_b, req_sel);
                exp_q.push_back(e);
                sent++;
            end
            if (rsp_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: unexpected data=%h sel=%b", rsp_data, rsp_sel);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_data !== e.data || rsp_sel !== e.sel) begin
                        n_fail++;
                        $display("FAIL stream_data[%0d]: data=%h sel=%b want %h/%b", got, rsp_data, rsp_sel, e.data, e.sel);
                    end
                end
                got++;
            end
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        n_tests++;
        if (got != 16 || ready_drop) begin
            n_fail++;
            $display("FAIL stream_count: got=%0d ready_drop=%b want 16/0", got, ready_drop);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        rsp_entry_t e;
        rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_a = 8'(10 + i); req_b = 8'(i); req_sel = 2'b00;
            if (req_ready) begin
                e.sel = 2'b00; e.data = st_ref(req_a, req_b, 2'b00);
                exp_q.push_back(e);
                acc++;
            end
            step();
        end
        req_valid = 1'b0;
        n_tests++;
        if (acc != 4 || req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: accepts=%0d req_ready=%b rsp_valid=%b want 4/0/1", acc, req_ready, rsp_valid);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) begin
                n_tests++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (rsp_data !== e.data || rsp_sel !== e.sel) begin
                    n_fail++;
                    $display("FAIL bp_drain[%0d]: data=%h sel=%b want %h/%b", got, rsp_data, rsp_sel, e.data, e.sel);
                end
                got++;
            end
            step();
        end
        rsp_ready = 1'b0;
        n_tests++;
        if (got != 4 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_empty: drained=%0d rsp_valid=%b req_ready=%b want 4/0/1", got, rsp_valid, req_ready);
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        int got = 0;
        rsp_entry_t e;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_a = 8'(20 + i); req_b = 8'd1; req_sel = 2'b00;
            if (req_ready) begin
                e.sel = 2'b00; e.data = st_ref(req_a, req_b, 2'b00);
                exp_q.push_back(e);
            end
            step();
        end
        req_valid = 1'b0;
        repeat (3) step();
        n_tests++;
        if (req_ready !== 1'b1 || dut.fifo_cnt !== 3'd3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL sim_fill: req_ready=%b fifo_cnt=%0d queued=%0d want 1/3/3", req_ready, dut.fifo_cnt, exp_q.size());
        end
        req_valid = 1'b1; req_a = 8'd30; req_b = 8'd7; req_sel = 2'b00;
        e.sel = 2'b00; e.data = st_ref(8'd30, 8'd7, 2'b00);
        exp_q.push_back(e);
        step();
        req_valid = 1'b0;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_credit: req_ready=%b want 0", req_ready);
        end
        step();
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        n_tests++;
        if (rsp_data !== e.data || dut.fifo_cnt !== 3'd3) begin
            n_fail++;
            $display("FAIL sim_head: data=%h fifo_cnt=%0d want %h/3", rsp_data, dut.fifo_cnt, e.data);
        end
        step();
        rsp_ready = 1'b0;
        n_tests++;
        if (dut.fifo_cnt !== 3'd3 || req_ready !== 1'b1 || rsp_data !== exp_q[0].data) begin
            n_fail++;
            $display("FAIL sim_pushpop: fifo_cnt=%0d req_ready=%b data=%h want 3/1/%h", dut.fifo_cnt, req_ready, rsp_data, exp_q[0].data);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) begin
                n_tests++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (rsp_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sim_drain[%0d]: data=%h want %h", got, rsp_data, e.data);
                end
                got++;
            end
            step();
        end
        rsp_ready = 1'b0;
        n_tests++;
        if (got != 3 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_count: drained=%0d rsp_valid=%b want 3/0", got, rsp_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        bit stale = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_a = 8'(40 + i); req_b = 8'd2; req_sel = 2'b00;
            step();
        end
        req_valid = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefill: rsp_valid=%b want 1", rsp_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || dp_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: rsp_valid=%b req_ready=%b dp_rst=%b want 0/0/1", rsp_valid, req_ready, dp_rst);
        end
        step();
        step();
        n_tests++;
        if (req_ready !== 1'b1 || dp_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_recover: req_ready=%b dp_rst=%b want 1/0", req_ready, dp_rst);
        end
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) stale = 1'b1;
            step();
        end
        n_tests++;
        if (stale) begin
            n_fail++;
            $display("FAIL mid_stale: stale response seen=%b want 0", stale);
        end
        req_valid = 1'b1; req_a = 8'd5; req_b = 8'd3; req_sel = 2'b00;
        step();
        req_valid = 1'b0;
        step();
        step();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h14 || rsp_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_fresh: valid=%b data=%h sel=%b want 1/14/00", rsp_valid, rsp_data, rsp_sel);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_final: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
